// File: rtl/tape_fetch_pkg.sv
// rtl/tape_fetch_pkg.sv - shared types and constants for the tape byte server
package tape_pkg;

  localparam int LINE_BYTES = 8;
  localparam int OFFS_W     = 3;
  localparam int ADDR_W_DEF = 25;
  localparam int TAG_W_DEF  = ADDR_W_DEF - OFFS_W;

  // Layout of one buffered line for the default tape address width.
  typedef struct packed {
    logic                    valid;
    logic [TAG_W_DEF-1:0]    tag;
    logic [LINE_BYTES*8-1:0] data;
  } line_t;

  typedef enum logic [2:0] {
    IDLE,
    DFETCH,
    PFETCH,
    SERVE,
    GAP
  } fetch_state_t;

  // Little-endian byte k of a 64-bit memory word.
  function automatic logic [7:0] byte_sel(input logic [LINE_BYTES*8-1:0] w,
                                          input logic [OFFS_W-1:0]       k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/tape_line_buf.sv
// rtl/tape_line_buf.sv - two-entry line buffer with hit compare, victim pointer and byte mux
module tape_line_buf
  import tape_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    i_clear,
  input  logic                    i_wr_en,
  input  logic [TAG_W-1:0]        i_wr_tag,
  input  logic [LINE_BYTES*8-1:0] i_wr_data,
  input  logic [TAG_W-1:0]        i_lk_tag,
  input  logic [OFFS_W-1:0]       i_lk_offs,
  input  logic [TAG_W-1:0]        i_pr_tag,
  output logic                    o_hit,
  output logic [7:0]              o_byte,
  output logic                    o_pr_present
);

  logic [1:0]              r_valid;
  logic [TAG_W-1:0]        r_tag  [2];
  logic [LINE_BYTES*8-1:0] r_data [2];
  logic                    r_victim;

  logic [1:0]              w_lk_match;
  logic [1:0]              w_pr_match;
  logic                    w_wr_way;

  // Tag compare of both entries against the demand line and the probe (next) line.
  always_comb begin
    w_lk_match = 2'b00;
    w_pr_match = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_lk_match[i] = r_valid[i] && (r_tag[i] == i_lk_tag);
      w_pr_match[i] = r_valid[i] && (r_tag[i] == i_pr_tag);
    end
  end

  assign o_hit        = |w_lk_match;
  assign o_pr_present = |w_pr_match;
  assign o_byte       = byte_sel(w_lk_match[1] ? r_data[1] : r_data[0], i_lk_offs);

  // An empty entry is always filled first; only a full buffer consults the pointer.
  assign w_wr_way = !r_valid[0] ? 1'b0 : (!r_valid[1] ? 1'b1 : r_victim);

  // Valid bits and victim pointer; clear drops lines but leaves the pointer alone.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 2'b00;
      r_victim <= 1'b0;
    end else if (i_clear) begin
      r_valid  <= 2'b00;
    end else if (i_wr_en) begin
      r_valid[w_wr_way] <= 1'b1;
      r_victim          <= ~r_victim;
    end
  end

  // Tag and data storage; contents are meaningless while the valid bit is low.
  always_ff @(posedge clk_sys) begin
    if (i_wr_en && !i_clear) begin
      r_tag[w_wr_way]  <= i_wr_tag;
      r_data[w_wr_way] <= i_wr_data;
    end
  end

endmodule

// File: rtl/tape_fetch.sv
// rtl/tape_fetch.sv - tape byte server with two-line buffer and next-line prefetch
module tape_fetch
  import tape_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter bit PREFETCH = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              tape_rd,
  input  logic [ADDR_W-1:0] tape_addr,
  output logic              tape_rd_en,
  output logic [7:0]        tape_din,
  output logic              mem_req,
  output logic [ADDR_W-4:0] mem_addr,
  input  logic              mem_ack,
  input  logic [63:0]       mem_dout
);

  localparam int TAG_W = ADDR_W - OFFS_W;

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;

  logic             r_tape_rd_en;
  logic [7:0]       r_tape_din;
  logic             r_mem_req;
  logic [TAG_W-1:0] r_mem_addr;

  logic [TAG_W-1:0] w_addr_line;
  logic [TAG_W-1:0] w_next_line;
  logic             w_hit;
  logic [7:0]       w_byte;
  logic             w_next_present;
  logic             w_ack_take;
  logic             w_req_set;
  logic [TAG_W-1:0] w_req_addr;

  assign w_addr_line = tape_addr[ADDR_W-1:OFFS_W];
  assign w_next_line = w_addr_line + 1'b1;

  // Data is only accepted while a fetch is outstanding; a flush in the same cycle discards it.
  assign w_ack_take = mem_ack && !flush && ((r_state == DFETCH) || (r_state == PFETCH));

  tape_line_buf #(
    .TAG_W (TAG_W)
  ) u_line_buf (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .i_clear      (flush),
    .i_wr_en      (w_ack_take),
    .i_wr_tag     (r_mem_addr),
    .i_wr_data    (mem_dout),
    .i_lk_tag     (w_addr_line),
    .i_lk_offs    (tape_addr[OFFS_W-1:0]),
    .i_pr_tag     (w_next_line),
    .o_hit        (w_hit),
    .o_byte       (w_byte),
    .o_pr_present (w_next_present)
  );

  // Fetch/serve state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and request launch; flush overrides everything and returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_req_set   = 1'b0;
    w_req_addr  = r_mem_addr;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (tape_rd) begin
            if (w_hit) begin
              w_state_nxt = SERVE;
            end else begin
              w_state_nxt = DFETCH;
              w_req_set   = 1'b1;
              w_req_addr  = w_addr_line;
            end
          end else if (PREFETCH && w_hit && !w_next_present) begin
            // Player is parked on a buffered line whose successor is missing.
            w_state_nxt = PFETCH;
            w_req_set   = 1'b1;
            w_req_addr  = w_next_line;
          end
        end
        DFETCH: begin
          if (mem_ack) w_state_nxt = SERVE;
        end
        PFETCH: begin
          // A demand that shows up now is picked up from IDLE after the fill.
          if (mem_ack) w_state_nxt = IDLE;
        end
        SERVE: begin
          w_state_nxt = GAP;
        end
        GAP: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Registered outputs: strobe and byte from SERVE, request held with fixed address until ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tape_rd_en <= 1'b0;
      r_tape_din   <= 8'h00;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else if (flush) begin
      r_tape_rd_en <= 1'b0;
      r_mem_req    <= 1'b0;
    end else begin
      r_tape_rd_en <= (r_state == SERVE);
      if (r_state == SERVE) begin
        r_tape_din <= w_byte;
      end
      if (w_req_set) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_req_addr;
      end else if (w_ack_take) begin
        r_mem_req  <= 1'b0;
      end
    end
  end

  assign tape_rd_en = r_tape_rd_en;
  assign tape_din   = r_tape_din;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule
